seg7_scan_driver: RTL and testbench

Multiplexed driver for a bank of common-cathode 7-segment digits. It generalises the single-digit hex decoder to `DIGITS` time-multiplexed digits, a programmable refresh rate and anti-ghosting dead time. Display updates use a ready/load handshake and take effect only at a scan-frame boundary, so the display never shows a half-updated value. It sits between the design's result registers and the board's segment and digit-select pins.

---
 rtl/seg7_scan_if.sv | 17 +
 rtl/seg7_scan_driver.sv | 166 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Load-side handshake bundle for seg7_scan_driver.
//   value   : 4*DIGITS hex nibbles. Nibble i drives digit i, and digit 0 is least significant.
//   dp_mask : decimal-point enable, one bit per digit.
//   load    : request to capture value/dp_mask.
//   ready   : high while a new load can be accepted.
// The master modport is the producer of display values. The slave modport is the driver.
interface seg7_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_mask;
    logic                load;
    logic                ready;

    modport master (output value, output dp_mask, output load, input ready);
    modport slave  (input value, input dp_mask, input load, output ready);
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for DIGITS common-cathode 7-segment digits.
// Each digit owns one slot of REFRESH_DIV cycles. The first DEAD_CYCLES cycles of a slot
// blank everything so that the previous digit does not ghost. New values come in through a
// ready/load handshake. They reach the display only at a frame boundary, which is the
// terminal count of the last digit slot.
//
// Ports:
//   clk      : single clock, rising edge.
//   rst_n    : asynchronous, active-low reset.
//   bus      : seg7_scan_if.slave (value, dp_mask, load in; ready out).
//   segments : bit0 = a ... bit6 = g, active-high, registered.
//   dp       : decimal point, active-high, registered.
//   digit_en : one-hot or all-zero digit select, active-high, registered.
//
// Optional feature: define SEG7_LZB_EN for leading-zero blanking. Digit 0 is never blanked.
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1024,
    parameter int DEAD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_if.slave        bus,
    output logic [6:0]        segments,
    output logic              dp,
    output logic [DIGITS-1:0] digit_en
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic                pend_full_q, pend_full_d;
    logic                ready_q, ready_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   digit_en_q, digit_en_d;
    logic [DIGITS-1:0]   blank;

    // Scan counters and the pending/displayed double buffer.
    always_comb begin
        logic tc;
        logic last;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        disp_val_d  = disp_val_q;
        disp_dp_d   = disp_dp_q;
        pend_full_d = pend_full_q;
        tc   = (cnt_q == CNT_LAST);
        last = (idx_q == IDX_LAST);
        if (tc) begin
            cnt_d = '0;
            idx_d = last ? '0 : idx_q + 1'b1;
        end
        // Transfer and accept are exclusive because both depend on pend_full_q.
        // A load accepted on the boundary cycle therefore waits one full frame.
        if (tc && last && pend_full_q) begin
            disp_val_d  = pend_val_q;
            disp_dp_d   = pend_dp_q;
            pend_full_d = 1'b0;
        end else if (bus.load && !pend_full_q) begin
            pend_val_d  = bus.value;
            pend_dp_d   = bus.dp_mask;
            pend_full_d = 1'b1;
        end
        ready_d = !pend_full_d;
    end

`ifdef SEG7_LZB_EN
    // A digit is blanked when it and every more-significant nibble are zero.
    always_comb begin
        logic hz;
        hz    = 1'b1;
        blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hz       = hz && (disp_val_q[4*i +: 4] == 4'h0);
            blank[i] = hz && (i != 0);
        end
    end
`else
    assign blank = '0;
`endif

    // Output stage: decode the current slot, or force everything off during dead time.
    always_comb begin
        logic       dead;
        logic [3:0] cur_nib;
        logic       cur_dp;
        logic       cur_blank;
        dead       = (int'(cnt_q) < DEAD_CYCLES);
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        digit_en_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib       = disp_val_q[4*i +: 4];
                cur_dp        = disp_dp_q[i];
                cur_blank     = blank[i];
                digit_en_d[i] = !dead;
            end
        end
        seg_d = (dead || cur_blank) ? 7'h00 : seg7_decode(cur_nib);
        dp_d  = !dead && cur_dp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_val_q  <= '0;
            pend_dp_q   <= '0;
            disp_val_q  <= '0;
            disp_dp_q   <= '0;
            pend_full_q <= 1'b0;
            ready_q     <= 1'b1;
            seg_q       <= '0;
            dp_q        <= 1'b0;
            digit_en_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_val_q  <= pend_val_d;
            pend_dp_q   <= pend_dp_d;
            disp_val_q  <= disp_val_d;
            disp_dp_q   <= disp_dp_d;
            pend_full_q <= pend_full_d;
            ready_q     <= ready_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            digit_en_q  <= digit_en_d;
        end
    end

    assign bus.ready = ready_q;
    assign segments  = seg_q;
    assign dp        = dp_q;
    assign digit_en  = digit_en_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2.
// The reference model derives the slot position from an absolute cycle count since reset.
// It keeps the pending and displayed values as plain words.
module tb_seg7_scan_driver;
    localparam int DIGITS = 4;
    localparam int RD     = 8;
    localparam int DEAD   = 2;
    localparam int FRAME  = DIGITS * RD;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    seg7_scan_if #(.DIGITS(DIGITS)) bus ();
    logic [6:0]        segments;
    logic              dp;
    logic [DIGITS-1:0] digit_en;

    seg7_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .DEAD_CYCLES(DEAD)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .segments(segments), .dp(dp), .digit_en(digit_en)
    );

    int checks   = 0;
    int failures = 0;

    logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef SEG7_LZB_EN
    localparam logic [6:0] ZERO_HI = 7'h00;
`else
    localparam logic [6:0] ZERO_HI = 7'h3F;
`endif

    // ---------------- reference model ----------------
    int          mk    = 0;   // cycles since reset release = state index sampled at next edge
    logic        mpf   = 1'b0;
    logic [15:0] mpend = '0, mdisp = '0;
    logic [3:0]  mpdp  = '0, mddp = '0;
    logic [3:0]  e_en  = '0;
    logic [6:0]  e_seg = '0;
    logic        e_dp  = 1'b0;
    logic        e_rdy = 1'b1;

    function automatic logic [3:0] m_en(input int k);
        if (k % RD < DEAD) return 4'b0;
        return 4'(1 << ((k / RD) % DIGITS));
    endfunction

    function automatic logic [6:0] m_seg(input int k, input logic [15:0] disp);
        int slot;
        logic [15:0] upper;
        slot  = (k / RD) % DIGITS;
        upper = disp >> (4 * slot);
        if (k % RD < DEAD) return 7'h00;
`ifdef SEG7_LZB_EN
        if (slot > 0 && upper == 16'h0) return 7'h00;
`endif
        return SEG_TAB[upper[3:0]];
    endfunction

    function automatic logic m_dp(input int k, input logic [3:0] ddp);
        if (k % RD < DEAD) return 1'b0;
        return ddp[(k / RD) % DIGITS];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mk <= 0; mpf <= 1'b0; mpend <= '0; mpdp <= '0; mdisp <= '0; mddp <= '0;
            e_en <= '0; e_seg <= '0; e_dp <= 1'b0; e_rdy <= 1'b1;
        end else begin
            e_en  <= m_en(mk);
            e_seg <= m_seg(mk, mdisp);
            e_dp  <= m_dp(mk, mddp);
            if ((mk % FRAME == FRAME - 1) && mpf) begin
                mdisp <= mpend; mddp <= mpdp; mpf <= 1'b0; e_rdy <= 1'b1;
            end else if (bus.load && !mpf) begin
                mpend <= bus.value; mpdp <= bus.dp_mask; mpf <= 1'b1; e_rdy <= 1'b0;
            end
            mk <= mk + 1;
        end
    end

    // ---------------- stimulus utilities (no checking inside) ----------------
    task automatic do_load(input logic [15:0] v, input logic [3:0] m, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (bus.ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) begin
            bus.load = 1'b1; bus.value = v; bus.dp_mask = m;
            @(negedge clk);
            bus.load = 1'b0;
        end
    endtask

    // Returns at the negedge where the outputs show cnt=0 of slot 0 with an empty pending buffer.
    task automatic wait_shown(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (mk % FRAME == 1 && !mpf) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        @(negedge clk); rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({digit_en, segments, dp} !== 12'h0 || bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got en=%b seg=%h dp=%b rdy=%b want 0/0/0/1",
                     digit_en, segments, dp, bus.ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int j = 0; j < FRAME; j++) begin
            int slot, c;
            logic [6:0] want;
            slot = j / RD; c = j % RD;
            want = (c < DEAD) ? 7'h00 : ((slot == 0) ? 7'h3F : ZERO_HI);
            checks++;
            if (segments !== want || digit_en !== ((c < DEAD) ? 4'b0 : 4'(1 << slot))
                || bus.ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_frame j=%0d got en=%b seg=%h rdy=%b want seg=%h",
                         j, digit_en, segments, bus.ready, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_scan;
        bit ok1, ok2;
        logic [6:0] want [4];
        want[0] = 7'h71; want[1] = 7'h5B; want[2] = 7'h77; want[3] = 7'h06;
        do_load(16'h1A2F, 4'b0, ok1);
        wait_shown(ok2);
        checks++;
        if (!(ok1 && ok2)) begin
            failures++;
            $display("FAIL scan_timeout got load_ok=%0d shown_ok=%0d want 1/1", ok1, ok2);
        end
        for (int j = 0; j < FRAME; j++) begin
            int slot, c;
            slot = j / RD; c = j % RD;
            checks++;
            if (c < DEAD) begin
                if (digit_en !== 4'b0 || segments !== 7'h0) begin
                    failures++;
                    $display("FAIL scan_dead j=%0d got en=%b seg=%h want 0/0", j, digit_en, segments);
                end
            end else if (digit_en !== 4'(1 << slot) || segments !== want[slot]) begin
                failures++;
                $display("FAIL scan_lit j=%0d got en=%b seg=%h want en=%b seg=%h",
                         j, digit_en, segments, 4'(1 << slot), want[slot]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_handshake;
        bit ok;
        logic [6:0] want [4];
        want[0] = 7'h66; want[1] = 7'h4F; want[2] = 7'h5B; want[3] = 7'h06;
        for (int t = 0; t < 64 && (mk % FRAME) != 10; t++) @(negedge clk);
        bus.load = 1'b1; bus.value = 16'h1234; bus.dp_mask = 4'b0;
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL hs_ready_low got %b want 0", bus.ready);
        end
        bus.value = 16'h5678;   // ignored: ready is low
        @(negedge clk);
        bus.load = 1'b0;
        while (mk % FRAME != 1) begin
            checks++;
            if ({digit_en, segments, dp, bus.ready} !== {e_en, e_seg, e_dp, e_rdy}) begin
                failures++;
                $display("FAIL hs_wait mk=%0d got en=%b seg=%h rdy=%b want en=%b seg=%h rdy=%b",
                         mk, digit_en, segments, bus.ready, e_en, e_seg, e_rdy);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL hs_ready_rise got %b want 1", bus.ready);
        end
        for (int j = 0; j < FRAME; j++) begin
            int slot, c;
            slot = j / RD; c = j % RD;
            if (c >= DEAD) begin
                checks++;
                if (segments !== want[slot] || digit_en !== 4'(1 << slot)) begin
                    failures++;
                    $display("FAIL hs_display j=%0d got en=%b seg=%h want seg=%h",
                             j, digit_en, segments, want[slot]);
                end
            end
            @(negedge clk);
        end
        wait_shown(ok);
        checks++;
        if (!ok || segments !== 7'h00 || bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL hs_no_queue got ok=%0d seg=%h rdy=%b want 1/00/1", ok, segments, bus.ready);
        end
    endtask

    task automatic test_boundary_load;
        int bad;
        bad = 0;
        for (int t = 0; t < 64 && (mk % FRAME) != FRAME - 1; t++) @(negedge clk);
        bus.load = 1'b1; bus.value = 16'h9C0D; bus.dp_mask = 4'b0;
        @(negedge clk);
        bus.load = 1'b0;
        checks++;
        if (bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL bnd_accept got ready=%b want 0", bus.ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (segments !== 7'h66 || digit_en !== 4'b0001) begin
            failures++;
            $display("FAIL bnd_old_frame got en=%b seg=%h want 0001/66", digit_en, segments);
        end
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (digit_en[0] && segments !== 7'h66) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bnd_early_show got %0d early cycles want 0", bad);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (segments !== 7'h5E || digit_en !== 4'b0001 || bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL bnd_new_frame got en=%b seg=%h rdy=%b want 0001/5e/1",
                     digit_en, segments, bus.ready);
        end
    endtask

    task automatic test_dp;
        bit ok1, ok2;
        do_load(16'h4321, 4'b0100, ok1);
        wait_shown(ok2);
        checks++;
        if (!(ok1 && ok2)) begin
            failures++;
            $display("FAIL dp_timeout got %0d/%0d want 1/1", ok1, ok2);
        end
        for (int j = 0; j < FRAME; j++) begin
            logic want;
            want = ((j / RD) == 2) && ((j % RD) >= DEAD);
            checks++;
            if (dp !== want) begin
                failures++;
                $display("FAIL dp_slot j=%0d got %b want %b", j, dp, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lzb;
        logic [15:0] vals [2];
        vals[0] = 16'h0050; vals[1] = 16'h0000;
        for (int v = 0; v < 2; v++) begin
            bit ok1, ok2;
            logic [6:0] want [4];
            want[0] = 7'h3F;
            want[1] = (v == 0) ? 7'h6D : ZERO_HI;
            want[2] = ZERO_HI; want[3] = ZERO_HI;
            do_load(vals[v], 4'b0, ok1);
            wait_shown(ok2);
            checks++;
            if (!(ok1 && ok2)) begin
                failures++;
                $display("FAIL lzb_timeout v=%0d got %0d/%0d want 1/1", v, ok1, ok2);
            end
            for (int j = 0; j < FRAME; j++) begin
                int slot, c;
                slot = j / RD; c = j % RD;
                if (c >= DEAD) begin
                    checks++;
                    if (segments !== want[slot] || digit_en !== 4'(1 << slot)) begin
                        failures++;
                        $display("FAIL lzb_digit v=%0d j=%0d got en=%b seg=%h want en=%b seg=%h",
                                 v, j, digit_en, segments, 4'(1 << slot), want[slot]);
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 800; i++) begin
            bus.load    = ($urandom_range(0, 5) == 0);
            bus.value   = 16'($urandom);
            bus.dp_mask = 4'($urandom);
            @(negedge clk);
            checks++;
            if ({digit_en, segments, dp, bus.ready} !== {e_en, e_seg, e_dp, e_rdy}) begin
                failures++;
                $display("FAIL random_model mk=%0d got en=%b seg=%h dp=%b rdy=%b want en=%b seg=%h dp=%b rdy=%b",
                         mk, digit_en, segments, dp, bus.ready, e_en, e_seg, e_dp, e_rdy);
            end
        end
        bus.load = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit ok1, ok2;
        wait_shown(ok1);
        do_load(16'h7777, 4'hF, ok2);
        checks++;
        if (!(ok1 && ok2)) begin
            failures++;
            $display("FAIL rstmid_timeout got %0d/%0d want 1/1", ok1, ok2);
        end
        for (int t = 0; t < 64 && (mk % FRAME) != 5; t++) @(negedge clk);
        checks++;
        if (bus.ready !== 1'b0 || digit_en !== 4'b0001) begin
            failures++;
            $display("FAIL rstmid_pending got rdy=%b en=%b want 0/0001", bus.ready, digit_en);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({digit_en, segments, dp} !== 12'h0 || bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_async got en=%b seg=%h dp=%b rdy=%b want 0/0/0/1",
                     digit_en, segments, dp, bus.ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int j = 0; j < FRAME + 8; j++) begin
            int slot, c;
            logic [6:0] want;
            slot = (j / RD) % DIGITS; c = j % RD;
            want = (c < DEAD) ? 7'h00 : ((slot == 0) ? 7'h3F : ZERO_HI);
            checks++;
            if (segments !== want || dp !== 1'b0 || bus.ready !== 1'b1
                || {digit_en, segments, dp, bus.ready} !== {e_en, e_seg, e_dp, e_rdy}) begin
                failures++;
                $display("FAIL rstmid_after j=%0d got en=%b seg=%h dp=%b rdy=%b want seg=%h dp=0 rdy=1",
                         j, digit_en, segments, dp, bus.ready, want);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bus.load = 1'b0; bus.value = '0; bus.dp_mask = '0;
        test_reset();
        test_scan();
        test_handshake();
        test_boundary_load();
        test_dp();
        test_lzb();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
